// File: rtl/riscv_pkg.sv
// RV32I(+M) decode constants, ALU codes and the ID/EX control bundle.
// Shared by the decode stage and anything downstream of it.
package riscv_pkg;

  localparam logic [6:0] OPC_LUI    = 7'b0110111;
  localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
  localparam logic [6:0] OPC_JAL    = 7'b1101111;
  localparam logic [6:0] OPC_JALR   = 7'b1100111;
  localparam logic [6:0] OPC_BRANCH = 7'b1100011;
  localparam logic [6:0] OPC_LOAD   = 7'b0000011;
  localparam logic [6:0] OPC_STORE  = 7'b0100011;
  localparam logic [6:0] OPC_IMM    = 7'b0010011;
  localparam logic [6:0] OPC_OP     = 7'b0110011;

  localparam logic [6:0] F7_BASE = 7'b0000000;
  localparam logic [6:0] F7_ALT  = 7'b0100000;
  localparam logic [6:0] F7_MULD = 7'b0000001;

  typedef enum logic [3:0] {
    ALU_ADD  = 4'd0,
    ALU_SUB  = 4'd1,
    ALU_MUL  = 4'd2,
    ALU_AND  = 4'd3,
    ALU_OR   = 4'd4,
    ALU_XOR  = 4'd5,
    ALU_SLL  = 4'd6,
    ALU_SRL  = 4'd7,
    ALU_SLT  = 4'd8,
    ALU_SLTU = 4'd9,
    ALU_LUI  = 4'd10,
    ALU_SRA  = 4'd11
  } alu_op_e;

  localparam logic [1:0] SZ_WORD = 2'b00;
  localparam logic [1:0] SZ_HALF = 2'b01;
  localparam logic [1:0] SZ_BYTE = 2'b10;

  localparam logic [1:0] WB_ALU = 2'b00;
  localparam logic [1:0] WB_MEM = 2'b01;
  localparam logic [1:0] WB_PC4 = 2'b10;

  localparam logic [1:0] JMP_NONE = 2'b00;
  localparam logic [1:0] JMP_BR   = 2'b01;
  localparam logic [1:0] JMP_JAL  = 2'b10;
  localparam logic [1:0] JMP_JALR = 2'b11;

  typedef struct packed {
    logic       mem_read;
    logic       mem_write;
    logic       reg_write;
    logic       alu_src;
    logic       alu_src_a;
    logic [1:0] mem_to_reg;
    logic [1:0] jump;
    logic [2:0] br_f3;
    logic [1:0] inst_size;
    logic       load_unsigned;
    alu_op_e    alu_op;
    logic [4:0] rs1;
    logic [4:0] rs2;
    logic [4:0] rd;
    logic       illegal;
  } id_ex_t;

  function automatic alu_op_e f3_alu(
    input logic [2:0] f3
  );
    case (f3)
      3'b000:  return ALU_ADD;
      3'b001:  return ALU_SLL;
      3'b010:  return ALU_SLT;
      3'b011:  return ALU_SLTU;
      3'b100:  return ALU_XOR;
      3'b101:  return ALU_SRL;
      3'b110:  return ALU_OR;
      default: return ALU_AND;
    endcase
  endfunction

  function automatic logic [1:0] mem_size(
    input logic [1:0] f
  );
    case (f)
      2'b00:   return SZ_BYTE;
      2'b01:   return SZ_HALF;
      default: return SZ_WORD;
    endcase
  endfunction

endpackage

// File: rtl/id_decode_comb.sv
// Purely combinational RV32I(+M) instruction decoder.
// Produces the control bundle plus register-use flags for hazard checks.
module id_decode_comb
  import riscv_pkg::*;
#(
  parameter bit M_EXT = 1'b0
) (
  input  logic [31:0] inst,
  output id_ex_t      ctrl,
  output logic        uses_rs1,
  output logic        uses_rs2
);

  logic [6:0] opc;
  logic [2:0] f3;
  logic [6:0] f7;
  logic       bad;

  assign opc = inst[6:0];
  assign f3  = inst[14:12];
  assign f7  = inst[31:25];

  assign uses_rs1 = !(opc == OPC_LUI ||
                      opc == OPC_AUIPC ||
                      opc == OPC_JAL);
  assign uses_rs2 = opc == OPC_OP ||
                    opc == OPC_STORE ||
                    opc == OPC_BRANCH;

  always_comb begin
    ctrl     = '0;
    bad      = 1'b0;
    ctrl.rs1 = inst[19:15];
    ctrl.rs2 = inst[24:20];
    ctrl.rd  = inst[11:7];
    unique case (1'b1)
      opc == OPC_LUI: begin
        ctrl.alu_op    = ALU_LUI;
        ctrl.alu_src   = 1'b1;
        ctrl.reg_write = 1'b1;
      end
      opc == OPC_AUIPC: begin
        ctrl.alu_src   = 1'b1;
        ctrl.alu_src_a = 1'b1;
        ctrl.reg_write = 1'b1;
      end
      opc == OPC_IMM: begin
        ctrl.alu_src   = 1'b1;
        ctrl.reg_write = 1'b1;
        ctrl.alu_op    = f3_alu(f3);
        if (f3 == 3'b001) begin
          bad = f7 != F7_BASE;
        end else if (f3 == 3'b101) begin
          if (f7 == F7_ALT) ctrl.alu_op = ALU_SRA;
          else bad = f7 != F7_BASE;
        end
      end
      opc == OPC_OP: begin
        ctrl.reg_write = 1'b1;
        case (f7)
          F7_BASE: ctrl.alu_op = f3_alu(f3);
          F7_ALT: begin
            if (f3 == 3'b000) ctrl.alu_op = ALU_SUB;
            else if (f3 == 3'b101) ctrl.alu_op = ALU_SRA;
            else bad = 1'b1;
          end
          F7_MULD: begin
            if (M_EXT && f3 == 3'b000) ctrl.alu_op = ALU_MUL;
            else bad = 1'b1;
          end
          default: bad = 1'b1;
        endcase
      end
      opc == OPC_LOAD: begin
        ctrl.mem_read      = 1'b1;
        ctrl.reg_write     = 1'b1;
        ctrl.mem_to_reg    = WB_MEM;
        ctrl.alu_src       = 1'b1;
        ctrl.inst_size     = mem_size(f3[1:0]);
        ctrl.load_unsigned = f3[2];
        bad = f3 == 3'b011 || f3 == 3'b110 || f3 == 3'b111;
      end
      opc == OPC_STORE: begin
        ctrl.mem_write = 1'b1;
        ctrl.alu_src   = 1'b1;
        ctrl.inst_size = mem_size(f3[1:0]);
        bad = f3 >= 3'b011;
      end
      opc == OPC_BRANCH: begin
        ctrl.alu_op = ALU_SUB;
        ctrl.jump   = JMP_BR;
        ctrl.br_f3  = f3;
      end
      opc == OPC_JAL: begin
        ctrl.jump       = JMP_JAL;
        ctrl.alu_src_a  = 1'b1;
        ctrl.reg_write  = 1'b1;
        ctrl.mem_to_reg = WB_PC4;
      end
      opc == OPC_JALR: begin
        ctrl.jump       = JMP_JALR;
        ctrl.alu_src    = 1'b1;
        ctrl.reg_write  = 1'b1;
        ctrl.mem_to_reg = WB_PC4;
      end
      default: bad = 1'b1;
    endcase
    // Illegal ops travel as inert bubbles that still carry their fields
    if (bad) begin
      ctrl         = '0;
      ctrl.rs1     = inst[19:15];
      ctrl.rs2     = inst[24:20];
      ctrl.rd      = inst[11:7];
      ctrl.illegal = 1'b1;
    end
  end

endmodule

// File: rtl/id_control_pipe.sv
// ID stage: decode, load-use hazard stall, ID/EX register with
// valid/ready handshake, branch flush and saturating stall counter.
module id_control_pipe
  import riscv_pkg::*;
#(
  parameter int XLEN        = 32,
  parameter bit M_EXT       = 1'b0,
  parameter int STALL_CNT_W = 16
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   in_valid,
  output logic                   in_ready,
  input  logic [31:0]            inst,
  input  logic [XLEN-1:0]        pc,
  input  logic                   flush,
  input  logic [4:0]             ex_rd,
  input  logic                   ex_mem_read,
  output logic                   out_valid,
  input  logic                   out_ready,
  output logic                   mem_read,
  output logic                   mem_write,
  output logic                   reg_write,
  output logic                   alu_src,
  output logic                   alu_src_a,
  output logic [1:0]             mem_to_reg,
  output logic [1:0]             jump,
  output logic [2:0]             br_f3,
  output logic [1:0]             inst_size,
  output logic                   load_unsigned,
  output logic [3:0]             alu_op,
  output logic [4:0]             rs1,
  output logic [4:0]             rs2,
  output logic [4:0]             rd,
  output logic [XLEN-1:0]        pc_out,
  output logic                   illegal,
  output logic [STALL_CNT_W-1:0] stall_cnt
);

  localparam logic [STALL_CNT_W-1:0] CNT_ONE = 1;

  id_ex_t dec;
  id_ex_t q;
  logic   uses_rs1;
  logic   uses_rs2;
  logic   hazard;
  logic   accept;

  id_decode_comb #(
    .M_EXT(M_EXT)
  ) u_dec (
    .inst     (inst),
    .ctrl     (dec),
    .uses_rs1 (uses_rs1),
    .uses_rs2 (uses_rs2)
  );

  assign hazard = ex_mem_read && ex_rd != 5'd0 &&
                  ((uses_rs1 && ex_rd == dec.rs1) ||
                   (uses_rs2 && ex_rd == dec.rs2));
  assign in_ready = !hazard && (!out_valid || out_ready);
  assign accept   = in_valid && in_ready;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      out_valid <= 1'b0;
      q         <= '0;
      pc_out    <= '0;
    end else begin
      if (flush) out_valid <= 1'b0;
      else if (accept) out_valid <= 1'b1;
      else if (out_ready) out_valid <= 1'b0;
      // A flushed accept never reaches the register
      if (accept && !flush) begin
        q      <= dec;
        pc_out <= pc;
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      stall_cnt <= '0;
    end else if (in_valid && hazard && stall_cnt != '1) begin
      stall_cnt <= stall_cnt + CNT_ONE;
    end
  end

  assign mem_read      = q.mem_read;
  assign mem_write     = q.mem_write;
  assign reg_write     = q.reg_write;
  assign alu_src       = q.alu_src;
  assign alu_src_a     = q.alu_src_a;
  assign mem_to_reg    = q.mem_to_reg;
  assign jump          = q.jump;
  assign br_f3         = q.br_f3;
  assign inst_size     = q.inst_size;
  assign load_unsigned = q.load_unsigned;
  assign alu_op        = q.alu_op;
  assign rs1           = q.rs1;
  assign rs2           = q.rs2;
  assign rd            = q.rd;
  assign illegal       = q.illegal;

endmodule

// File: tb/tb_id_control_pipe.sv
// Scoreboard bench for id_control_pipe: two DUTs (M_EXT=0/16-bit counter,
// M_EXT=1/4-bit counter) share stimulus and are checked against a decode model.
module tb_id_control_pipe;

  typedef struct packed {
    logic        mr;
    logic        mw;
    logic        rw;
    logic        as;
    logic        asa;
    logic [1:0]  m2r;
    logic [1:0]  jmp;
    logic [2:0]  bf3;
    logic [1:0]  sz;
    logic        lu;
    logic [3:0]  alu;
    logic [4:0]  rs1;
    logic [4:0]  rs2;
    logic [4:0]  rd;
    logic        ill;
    logic [31:0] pc;
  } exp_t;

  // ALU code for funct3 0..7 of the base (funct7=0) integer ops
  localparam int F3ALU [8] = '{0, 6, 8, 9, 5, 7, 4, 3};
  localparam logic [6:0] OPS [9] = '{7'h37, 7'h17, 7'h13, 7'h33,
    7'h03, 7'h23, 7'h63, 7'h6F, 7'h67};

  localparam logic [31:0] I_ADDI = 32'h00500093;
  localparam logic [31:0] I_ADD  = 32'h002081B3;
  localparam logic [31:0] I_SW   = 32'h0020A023;
  localparam logic [31:0] I_JAL  = 32'h008000EF;
  localparam logic [31:0] I_MUL  = 32'h022081B3;
  localparam logic [31:0] I_NOP  = 32'h00000013;

  logic clk = 1'b0;
  logic reset = 1'b1;
  logic in_valid, flush, ex_mem_read, out_ready;
  logic [31:0] inst, pc;
  logic [4:0] ex_rd;

  logic in_ready [2];
  logic out_valid [2];
  logic mem_read [2];
  logic mem_write [2];
  logic reg_write [2];
  logic alu_src [2];
  logic alu_src_a [2];
  logic load_unsigned [2];
  logic illegal [2];
  logic [1:0] mem_to_reg [2];
  logic [1:0] jump [2];
  logic [1:0] inst_size [2];
  logic [2:0] br_f3 [2];
  logic [3:0] alu_op [2];
  logic [4:0] rs1 [2];
  logic [4:0] rs2 [2];
  logic [4:0] rd [2];
  logic [31:0] pc_out [2];
  logic [15:0] sc [2];

  int total = 0;
  int bad = 0;
  exp_t q [2][$];
  int cnt [2];
  bit acc [2];

  always #5 clk = ~clk;

  for (genvar g = 0; g < 2; g++) begin : g_dut
    logic [(g == 1 ? 4 : 16)-1:0] s;
    id_control_pipe #(
      .XLEN(32), .M_EXT(g == 1), .STALL_CNT_W(g == 1 ? 4 : 16)
    ) u_dut (
      .clk(clk), .reset(reset),
      .in_valid(in_valid), .in_ready(in_ready[g]),
      .inst(inst), .pc(pc), .flush(flush),
      .ex_rd(ex_rd), .ex_mem_read(ex_mem_read),
      .out_valid(out_valid[g]), .out_ready(out_ready),
      .mem_read(mem_read[g]), .mem_write(mem_write[g]),
      .reg_write(reg_write[g]), .alu_src(alu_src[g]),
      .alu_src_a(alu_src_a[g]), .mem_to_reg(mem_to_reg[g]),
      .jump(jump[g]), .br_f3(br_f3[g]),
      .inst_size(inst_size[g]), .load_unsigned(load_unsigned[g]),
      .alu_op(alu_op[g]), .rs1(rs1[g]), .rs2(rs2[g]), .rd(rd[g]),
      .pc_out(pc_out[g]), .illegal(illegal[g]), .stall_cnt(s)
    );
    assign sc[g] = 16'(s);
  end

  task automatic chk(input string nm, input logic [95:0] a,
                     input logic [95:0] e);
    total++;
    if (a !== e) begin
      bad++;
      $display("FAIL %s actual=%0h required=%0h t=%0t", nm, a, e, $time);
    end
  endtask

  function automatic exp_t model(input logic [31:0] i,
                                 input logic [31:0] p, input bit m);
    exp_t e;
    logic [6:0] op, f7;
    logic [2:0] f3;
    bit ok;
    int s;
    e = '0;
    op = i[6:0];
    f3 = i[14:12];
    f7 = i[31:25];
    ok = 1'b1;
    s = 2 - int'(i[13:12]);
    case (op)
      7'h37: begin e.alu = 10; e.as = 1; e.rw = 1; end
      7'h17: begin e.as = 1; e.asa = 1; e.rw = 1; end
      7'h13: begin
        e.as = 1; e.rw = 1;
        if (f3 == 1) begin e.alu = 6; ok = f7 == 0; end
        else if (f3 == 5) begin
          ok = f7 == 0 || f7 == 7'h20;
          e.alu = (f7 == 7'h20) ? 4'd11 : 4'd7;
        end else e.alu = 4'(F3ALU[f3]);
      end
      7'h33: begin
        e.rw = 1;
        if (f7 == 0) e.alu = 4'(F3ALU[f3]);
        else if (f7 == 7'h20 && f3 == 0) e.alu = 1;
        else if (f7 == 7'h20 && f3 == 5) e.alu = 11;
        else if (f7 == 7'h01 && f3 == 0 && m) e.alu = 2;
        else ok = 0;
      end
      7'h03: begin
        e.mr = 1; e.rw = 1; e.m2r = 1; e.as = 1;
        e.sz = s[1:0]; e.lu = f3 > 3;
        ok = f3 inside {3'd0, 3'd1, 3'd2, 3'd4, 3'd5};
      end
      7'h23: begin
        e.mw = 1; e.as = 1; e.sz = s[1:0]; ok = f3 < 3;
      end
      7'h63: begin e.alu = 1; e.jmp = 1; e.bf3 = f3; end
      7'h6F: begin e.jmp = 2; e.asa = 1; e.rw = 1; e.m2r = 2; end
      7'h67: begin e.jmp = 3; e.as = 1; e.rw = 1; e.m2r = 2; end
      default: ok = 0;
    endcase
    if (!ok) begin e = '0; e.ill = 1; end
    e.rs1 = i[19:15];
    e.rs2 = i[24:20];
    e.rd = i[11:7];
    e.pc = p;
    return e;
  endfunction

  function automatic bit haz(input logic [31:0] i, input logic emr,
                             input logic [4:0] erd);
    bit u1, u2;
    u1 = !(i[6:0] inside {7'h37, 7'h17, 7'h6F});
    u2 = i[6:0] inside {7'h33, 7'h23, 7'h63};
    return emr && erd != 0 &&
      ((u1 && erd == i[19:15]) || (u2 && erd == i[24:20]));
  endfunction

  function automatic exp_t obs(input int k);
    exp_t o;
    o.mr = mem_read[k]; o.mw = mem_write[k]; o.rw = reg_write[k];
    o.as = alu_src[k]; o.asa = alu_src_a[k]; o.m2r = mem_to_reg[k];
    o.jmp = jump[k]; o.bf3 = br_f3[k]; o.sz = inst_size[k];
    o.lu = load_unsigned[k]; o.alu = alu_op[k]; o.rs1 = rs1[k];
    o.rs2 = rs2[k]; o.rd = rd[k]; o.ill = illegal[k]; o.pc = pc_out[k];
    return o;
  endfunction

  function automatic logic [31:0] rand_inst();
    logic [6:0] op, f7;
    int r;
    r = $urandom_range(0, 9);
    op = (r < 9) ? OPS[r] : 7'($urandom);
    case ($urandom_range(0, 3))
      0: f7 = 7'h00;
      1: f7 = 7'h20;
      2: f7 = 7'h01;
      default: f7 = 7'($urandom);
    endcase
    return {f7, 5'($urandom_range(0, 3)), 5'($urandom_range(0, 3)),
            3'($urandom), 5'($urandom), op};
  endfunction

  // Monitor: compare whatever the DUTs present against the queued model
  always @(negedge clk) begin
    if (reset) begin
      for (int k = 0; k < 2; k++) begin
        q[k].delete();
        cnt[k] = 0;
        acc[k] = 0;
      end
    end else begin
      for (int k = 0; k < 2; k++) begin
        bit hz, rdy;
        int mx;
        mx = (k == 0) ? 16'hFFFF : 16'h000F;
        hz = haz(inst, ex_mem_read, ex_rd);
        rdy = !hz && (q[k].size() == 0 || out_ready);
        chk($sformatf("in_ready%0d", k), 96'(in_ready[k]), 96'(rdy));
        chk($sformatf("out_valid%0d", k), 96'(out_valid[k]),
            96'(q[k].size() != 0));
        if (q[k].size() != 0) begin
          chk($sformatf("bundle%0d", k), 96'(obs(k)), 96'(q[k][0]));
          if (out_ready || flush) void'(q[k].pop_front());
        end
        chk($sformatf("stall_cnt%0d", k), 96'(sc[k]), 96'(cnt[k]));
        if (in_valid && hz && cnt[k] != mx) cnt[k]++;
        acc[k] = in_valid && rdy && !flush;
      end
    end
  end

  // Issue side: record the expected bundle for every accepted instruction
  always @(negedge clk) begin
    #2;
    if (!reset) begin
      for (int k = 0; k < 2; k++)
        if (acc[k]) q[k].push_back(model(inst, pc, k == 1));
    end
  end

  task automatic cyc(input logic v, input logic [31:0] i,
                     input logic fl, input logic [4:0] erd,
                     input logic emr, input logic ordy);
    @(posedge clk);
    #1;
    in_valid = v;
    inst = i;
    pc = pc + 32'd4;
    flush = fl;
    ex_rd = erd;
    ex_mem_read = emr;
    out_ready = ordy;
    #1;
  endtask

  task automatic rand_cyc();
    cyc(($urandom % 10) < 8, rand_inst(), ($urandom % 12) == 0,
        5'($urandom_range(0, 3)), ($urandom % 3) == 0,
        ($urandom % 4) != 0);
  endtask

  initial begin
    exp_t snap;
    logic [15:0] s0;
    in_valid = 0; inst = I_NOP; pc = 32'h100; flush = 0;
    ex_rd = 0; ex_mem_read = 0; out_ready = 1;
    #1;
    chk("rst_valid", 96'(out_valid[0]), 96'(0));
    chk("rst_cnt", 96'(sc[0]), 96'(0));
    chk("rst_bundle", 96'(obs(0)), 96'(0));
    repeat (2) @(posedge clk);
    #1 reset = 0;

    cyc(1, I_ADDI, 0, 0, 0, 1);
    cyc(0, I_NOP, 0, 0, 0, 1);
    chk("addi_valid", 96'(out_valid[0]), 96'(1));
    chk("addi_ctl", 96'({alu_op[0], alu_src[0], reg_write[0]}),
        96'({4'd0, 1'b1, 1'b1}));
    chk("addi_rd", 96'({rd[0], illegal[0]}), 96'({5'd1, 1'b0}));

    cyc(1, I_ADD, 0, 2, 1, 1);
    s0 = sc[0];
    chk("haz_rdy_a", 96'(in_ready[0]), 96'(0));
    cyc(1, I_ADD, 0, 2, 1, 1);
    chk("haz_rdy_b", 96'(in_ready[0]), 96'(0));
    cyc(1, I_ADD, 0, 2, 1, 1);
    chk("haz_bubble", 96'(out_valid[0]), 96'(0));
    cyc(1, I_ADD, 0, 2, 0, 1);
    chk("haz_cnt", 96'(sc[0]), 96'(s0 + 16'd3));
    chk("haz_release", 96'(in_ready[0]), 96'(1));
    cyc(0, I_NOP, 0, 0, 0, 1);
    chk("add_out", 96'({out_valid[0], rd[0]}), 96'({1'b1, 5'd3}));

    cyc(1, I_SW, 0, 0, 0, 1);
    cyc(0, I_NOP, 0, 0, 0, 0);
    snap = obs(0);
    chk("sw_ctl", 96'({out_valid[0], mem_write[0], inst_size[0]}),
        96'({1'b1, 1'b1, 2'b00}));
    chk("sw_rdy", 96'(in_ready[0]), 96'(0));
    cyc(0, I_NOP, 0, 0, 0, 0);
    chk("sw_hold", 96'(obs(0)), 96'(snap));
    chk("sw_hold_v", 96'(out_valid[0]), 96'(1));

    cyc(1, I_JAL, 1, 0, 0, 1);
    cyc(0, I_NOP, 0, 0, 0, 1);
    chk("flush_v0", 96'(out_valid[0]), 96'(0));
    chk("flush_v1", 96'(out_valid[1]), 96'(0));

    cyc(1, I_MUL, 0, 0, 0, 1);
    cyc(0, I_NOP, 0, 0, 0, 1);
    chk("mul_m0", 96'({illegal[0], reg_write[0]}), 96'({1'b1, 1'b0}));
    chk("mul_m1", 96'({illegal[1], reg_write[1], alu_op[1]}),
        96'({1'b0, 1'b1, 4'd2}));

    repeat (1500) rand_cyc();

    cyc(1, I_ADDI, 0, 0, 0, 0);
    cyc(0, I_NOP, 0, 0, 0, 0);
    chk("mid_pre_v", 96'(out_valid[0]), 96'(1));
    #1 reset = 1;
    #1;
    chk("mid_rst_v", 96'({out_valid[0], out_valid[1]}), 96'(0));
    chk("mid_rst_cnt", 96'({sc[0], sc[1]}), 96'(0));
    @(posedge clk);
    #1 reset = 0;

    repeat (300) rand_cyc();
    cyc(0, I_NOP, 0, 0, 0, 1);
    cyc(0, I_NOP, 0, 0, 0, 1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
